// File: rtl/audio_mavg_if.sv
// Sample-stream bundle between the codec read side and the moving-average filter.
// Carries one packed multi-channel input stream and one packed output stream.
interface audio_mavg_if #(
  parameter int DATA_W = 24,
  parameter int NCH    = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [NCH*DATA_W-1:0]   in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [NCH*DATA_W-1:0]   out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/audio_mavg_filter.sv
// Multi-channel moving-average low-pass filter with bypass and sequenced window clear.
// Each channel keeps a circular window of 2^LOG2_TAPS samples and a running sum.
module audio_mavg_filter #(
  parameter int DATA_W    = 24,
  parameter int LOG2_TAPS = 3,
  parameter int NCH       = 2
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          clear,
  input  logic          bypass,
  output logic          clearing,
  audio_mavg_if.slave   bus
);

  localparam int N  = 1 << LOG2_TAPS;
  localparam int SW = DATA_W + LOG2_TAPS;

  typedef enum logic {ST_CLR, ST_RUN} state_e;

  state_e                  state_q;
  logic [LOG2_TAPS-1:0]    wr_idx_q;
  logic signed [SW-1:0]    sum_q  [NCH];
  logic signed [SW-1:0]    sum_d  [NCH];
  logic [DATA_W-1:0]       buf_q  [NCH][N];
  logic [DATA_W-1:0]       in_ch  [NCH];
  logic [DATA_W-1:0]       old_ch [NCH];
  logic signed [SW-1:0]    avg_ch [NCH];
  logic                    out_valid_q;
  logic [NCH*DATA_W-1:0]   out_data_q;
  logic [NCH*DATA_W-1:0]   out_data_d;
  logic                    accept;

  assign clearing      = (state_q == ST_CLR);
  assign bus.in_ready  = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  always_comb begin
    out_data_d = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      in_ch[c]  = bus.in_data[c*DATA_W +: DATA_W];
      old_ch[c] = buf_q[c][wr_idx_q];
      sum_d[c]  = sum_q[c]
                + $signed({{LOG2_TAPS{in_ch[c][DATA_W-1]}}, in_ch[c]})
                - $signed({{LOG2_TAPS{old_ch[c][DATA_W-1]}}, old_ch[c]});
      // Arithmetic shift floors toward -inf; the mean always fits in DATA_W.
      avg_ch[c] = sum_d[c] >>> LOG2_TAPS;
      out_data_d[c*DATA_W +: DATA_W] = bypass ? in_ch[c] : avg_ch[c][DATA_W-1:0];
    end
  end

  // Window storage needs no reset: the CLR sweep zeroes it after every reset or clear.
  always_ff @(posedge CLOCK_50) begin
    for (int unsigned c = 0; c < NCH; c++) begin
      if (state_q == ST_CLR) begin
        buf_q[c][wr_idx_q] <= '0;
      end else if (accept) begin
        buf_q[c][wr_idx_q] <= in_ch[c];
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= ST_CLR;
      wr_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int unsigned c = 0; c < NCH; c++) sum_q[c] <= '0;
    end else if (state_q == ST_CLR) begin
      wr_idx_q <= wr_idx_q + 1'b1;
      if (&wr_idx_q) state_q <= ST_RUN;
    end else if (clear) begin
      state_q     <= ST_CLR;
      wr_idx_q    <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) sum_q[c] <= '0;
    end else begin
      if (accept) begin
        for (int unsigned c = 0; c < NCH; c++) sum_q[c] <= sum_d[c];
        wr_idx_q    <= wr_idx_q + 1'b1;
        out_valid_q <= 1'b1;
        out_data_q  <= out_data_d;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_mavg_filter.sv
// Scoreboard bench for audio_mavg_filter: a reference window model pushes expected
// outputs on each accepted input; a negedge monitor pops and compares taken outputs.
module tb_audio_mavg_filter;

  localparam int DW = 24;
  localparam int NC = 2;
  localparam int LT = 3;
  localparam int N  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic bypass = 1'b0;
  logic clearing;

  audio_mavg_if #(.DATA_W(DW), .NCH(NC)) bus ();

  audio_mavg_filter #(.DATA_W(DW), .LOG2_TAPS(LT), .NCH(NC)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .clear    (clear),
    .bypass   (bypass),
    .clearing (clearing),
    .bus      (bus)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [NC*DW-1:0] sb_q [$];
  logic [NC*DW-1:0] last_exp;
  logic [NC*DW-1:0] mon_e;
  longint           win [NC][N];
  int               widx;

  task automatic check(input string tag, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic longint floor_div(input longint s);
    longint q;
    q = s / N;
    if (s < 0 && (s % N) != 0) q = q - 1;
    return q;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < N; i++) win[c][i] = 0;
    widx = 0;
    sb_q.delete();
  endtask

  task automatic model_accept(input longint d0, input longint d1, input logic byp);
    longint           dv [NC];
    longint           s;
    longint           val;
    logic [63:0]      v;
    logic [NC*DW-1:0] e;
    dv[0] = d0;
    dv[1] = d1;
    e = '0;
    for (int c = 0; c < NC; c++) begin
      win[c][widx] = dv[c];
      s = 0;
      for (int i = 0; i < N; i++) s += win[c][i];
      val = byp ? dv[c] : floor_div(s);
      v = val;
      e[c*DW +: DW] = v[DW-1:0];
    end
    widx = (widx + 1) % N;
    sb_q.push_back(e);
    last_exp = e;
  endtask

  task automatic send(input longint d0, input longint d1, input logic byp);
    int          w;
    logic [63:0] a;
    logic [63:0] b;
    w = 0;
    a = d0;
    b = d1;
    @(posedge clk); #1;
    bus.in_data  = {b[DW-1:0], a[DW-1:0]};
    bus.in_valid = 1'b1;
    bypass       = byp;
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    check("in_ready_wait", bus.in_ready, 1);
    if (bus.in_ready) model_accept(d0, d1, byp);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("out_latency", bus.out_valid, 1);
  endtask

  task automatic wait_clr(input string tag);
    int cnt;
    int bad;
    cnt = 0;
    bad = 0;
    @(negedge clk);
    while (clearing && cnt < 40) begin
      if (bus.in_ready) bad++;
      cnt++;
      @(negedge clk);
    end
    check({tag, "_clr_cycles"}, cnt, N);
    check({tag, "_clr_in_ready"}, bad, 0);
    check({tag, "_run_in_ready"}, bus.in_ready, 1);
    check({tag, "_run_out_valid"}, bus.out_valid, 0);
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
    check("clear_out_valid", bus.out_valid, 0);
    check("clear_clearing", clearing, 1);
  endtask

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", bus.out_valid, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("out_ch0", $signed(bus.out_data[DW-1:0]), $signed(mon_e[DW-1:0]));
        check("out_ch1", $signed(bus.out_data[2*DW-1:DW]), $signed(mon_e[2*DW-1:DW]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NC*DW-1:0] exp_a;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    model_clear();

    // Reset and initial clear sweep
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_clr("reset");
    check("reset_out_data", bus.out_data, 0);

    // Step ramp, then wrap with oldest-sample subtraction
    for (int i = 0; i < 8; i++) send(1000000, 0, 1'b0);
    for (int i = 0; i < 8; i++) send(1000008, 0, 1'b0);

    // Negative samples from a cleared window
    do_clear();
    wait_clr("clear1");
    send(0, -7, 1'b0);
    for (int i = 0; i < 8; i++) send(0, -800, 1'b0);

    // Backpressure: output held, input stalled, then simultaneous take and accept
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(111, 222, 1'b0);
    exp_a = last_exp;
    fork
      send(333, -444, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("hold_out_data", bus.out_data, exp_a);
          check("hold_in_ready", bus.in_ready, 0);
          check("hold_out_valid", bus.out_valid, 1);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join

    // Bypass, then back to averaging on the same warm window
    send(5, 5, 1'b1);
    send(1000000, -1000000, 1'b0);

    // Clear with a pending output, then fresh window
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(77, 88, 1'b0);
    do_clear();
    bus.out_ready = 1'b1;
    wait_clr("clear2");
    send(1000000, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drain", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_mavg_filter.md
Name: audio_mavg_filter

Overview:
Parametrised multi-channel moving-average low-pass filter for the audio codec sample path. It sits between the codec read interface (read_ready / readdata_left / readdata_right) and the codec write interface. It takes one signed sample per channel per handshake and outputs the mean of the last 2^LOG2_TAPS samples for each channel. It adds a bypass mode and a sequenced buffer clear, which the fixed single-channel averager in the current design does not have.

Parameters:
DATA_W, 24, signed sample width per channel
LOG2_TAPS, 3, log2 of window length N (N = 8 by default); legal range 1..6
NCH, 2, channel count; channel 0 occupies the LSBs of packed buses (0 = left, 1 = right)

Ports:
CLOCK_50  in  1  sole clock; all logic on posedge
reset  in  1  synchronous, active-high reset
clear  in  1  one-cycle pulse; zeroes the window without a full reset
bypass  in  1  1 = output the raw input sample; sampled on input handshake
in_valid  in  1  input sample set valid
in_ready  out  1  block can accept a sample set
in_data  in  NCH*DATA_W  packed signed samples
out_valid  out  1  output sample set valid
out_ready  in  1  downstream accepts the output
out_data  out  NCH*DATA_W  packed signed filtered samples
clearing  out  1  high while the window is being zeroed

Behaviour:
- Storage: per-channel circular buffer of N x DATA_W plus one shared write index wr_idx (LOG2_TAPS bits). Per-channel running sum of DATA_W+LOG2_TAPS bits, signed.
- FSM has two states, CLR and RUN.
  - reset=1 forces CLR with wr_idx=0, all sums=0, out_valid=0, out_data=0.
  - In CLR, each cycle writes zero to buffer[wr_idx] for every channel and increments wr_idx. After the write at index N-1, wr_idx wraps to 0 and the FSM goes to RUN. CLR therefore lasts exactly N cycles after reset deasserts.
  - clearing = (state==CLR). in_ready = 0 in CLR.
- clear pulse in RUN: next state is CLR, wr_idx=0, sums=0, out_valid=0 (any pending output is dropped). clear is ignored while already in CLR. clear and reset together behave as reset.
- in_ready = (state==RUN) && (!out_valid || out_ready). This gives a single output register with full throughput.
- Input handshake (in_valid && in_ready), per channel c:
  - sum_c <= sum_c + sext(in_c) - sext(buffer_c[wr_idx])
  - buffer_c[wr_idx] <= in_c, and wr_idx increments modulo N (wraps N-1 -> 0).
  - out_c <= bypass ? in_c : (sum_c + sext(in_c) - sext(old_c)) >>> LOG2_TAPS. The shift is arithmetic (floor toward negative infinity) and keeps the low DATA_W bits. The result always fits in DATA_W bits; no saturation is needed.
  - out_valid <= 1.
- Latency: out_data is valid on the cycle after the input handshake.
- Buffer and sums are updated in bypass too, so leaving bypass gives a correct average with no re-warm.
- Output: while out_valid && !out_ready, out_data is held stable. out_valid clears on (out_valid && out_ready && !accepting new input). An accept in the same cycle as a downstream take keeps out_valid=1 with the new data.
- Warm-up: the window starts zero-filled, so the first N-1 outputs ramp. No separate fill flag.
- Reset mid-stream aborts everything. The first post-reset in_ready occurs N cycles after reset falls.

Test Plan:
1. Reset 2 cycles, then release. Required: clearing=1 and in_ready=0 for exactly 8 cycles, then in_ready=1, out_valid=0, out_data=0.
2. Feed 8 handshakes of ch0=1000000, ch1=0 with out_ready=1. Required ch0 outputs: 125000, 250000, 375000, 500000, 625000, 750000, 875000, 1000000; ch1 stays 0. Each output appears 1 cycle after its input.
3. Continue after test 2 with ch0 = 1000008 for 8 samples. Required: the output rises by exactly 1 per sample (1000001 .. 1000008), confirming oldest-sample subtraction and index wrap.
4. From cleared state, feed ch1 = -7 once, then -800 repeatedly. Required: first output -1 (floor of -7/8). After 8 samples of -800 the output is -800. Check sign handling via negative sums.
5. Hold out_ready=0 with in_valid=1. Required: out_data frozen, in_ready=0, no buffer update. Then raise out_ready together with in_valid. Required: new sample accepted the same cycle, out_valid stays 1.
6. Set bypass=1 and feed 5: required output 5. Pulse clear mid-stream: required out_valid drops, 8 CLR cycles, then feeding 1000000 yields 125000.
